// File: rtl/dpram_bist.sv
// Built-in self-test initiator for the dpram cell: fills the memory with a Galois LFSR
// pattern, reads it back and compares every word. Optional macro: DPRAM_BIST_INVERSE_PASS_EN.
module dpram_bist #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          LAST_ADDR  = 1023,
  parameter logic [31:0] SEED       = 32'hACE1_2468,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] d_in,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] d_out
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] TAPS     = 32'h8020_0003;
  localparam logic [DATA_WIDTH-1:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [ADDR_WIDTH-1:0] LAST     = LAST_ADDR[ADDR_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0]   exp_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    vld_q;
  logic [CNT_WIDTH-1:0]    fail_q;
  logic [ADDR_WIDTH-1:0]   first_q;
  logic                    clearRes;
  logic [DATA_WIDTH-1:0]   polMask;
  logic [DATA_WIDTH-1:0]   lfsrNext;

  assign lfsrNext = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

`ifdef DPRAM_BIST_INVERSE_PASS_EN
  logic phase_q, phase_d;

  // Second pass runs the same pattern inverted so each cell sees both polarities.
  assign polMask = {DATA_WIDTH{phase_q}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= phase_d;
  end
`else
  assign polMask = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED_EFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    clearRes = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    wen      = 1'b0;
    waddr    = '0;
    d_in     = '0;
    ren      = 1'b0;
    raddr    = '0;
`ifdef DPRAM_BIST_INVERSE_PASS_EN
    phase_d  = phase_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          state_d  = WRITE;
          cnt_d    = '0;
          lfsr_d   = SEED_EFF;
          clearRes = 1'b1;
`ifdef DPRAM_BIST_INVERSE_PASS_EN
          phase_d  = 1'b0;
`endif
        end
      end
      WRITE: begin
        busy   = 1'b1;
        wen    = 1'b1;
        waddr  = cnt_q;
        d_in   = lfsr_q ^ polMask;
        lfsr_d = lfsrNext;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READ;
          cnt_d   = '0;
          lfsr_d  = SEED_EFF;
        end
      end
      READ: begin
        busy   = 1'b1;
        ren    = 1'b1;
        raddr  = cnt_q;
        lfsr_d = lfsrNext;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
`ifdef DPRAM_BIST_INVERSE_PASS_EN
        if (!phase_q) begin
          state_d = WRITE;
          phase_d = 1'b1;
          lfsr_d  = SEED_EFF;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data returns one cycle after the request, so the expected word and its
  // address ride a one-stage pipeline and are compared against d_out the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      fail_q  <= '0;
      first_q <= '0;
    end else begin
      vld_q  <= ren;
      exp_q  <= lfsr_q ^ polMask;
      addr_q <= cnt_q;
      if (clearRes) begin
        fail_q  <= '0;
        first_q <= '0;
      end else if (vld_q && (d_out != exp_q)) begin
        if (fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
        if (fail_q == '0)      first_q <= addr_q;
      end
    end
  end

  assign fail_count     = fail_q;
  assign first_err_addr = first_q;
  assign pass           = done && (fail_q == '0);

endmodule

// File: tb/tb_dpram_bist.sv
// Self-checking bench for dpram_bist: behavioural dpram with per-address bit-5 fault
// injection, table-driven runs plus reset/idle and reset-mid-run sequences.
module tb_dpram_bist;

  localparam int          AW   = 10;
  localparam int          DW   = 32;
  localparam int          LAST = 1023;
  localparam int          CW   = 16;
  localparam logic [31:0] SEED = 32'hACE1_2468;
`ifdef DPRAM_BIST_INVERSE_PASS_EN
  localparam int PASSES   = 2;
  localparam int DONE_CYC = 4*(LAST+1)+3;
`else
  localparam int PASSES   = 1;
  localparam int DONE_CYC = 2*(LAST+1)+2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, wen, ren;
  logic [CW-1:0] fail_count;
  logic [AW-1:0] first_err_addr, waddr, raddr;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out = '0;

  logic [DW-1:0] mem [0:LAST];
  logic          faultMask [0:LAST];
  logic [31:0]   seq [0:LAST];

  int errors = 0;
  int checks = 0;

  typedef struct {
    string name;
    int    nf;
    int    fa [3];
    int    firstExp;
    bit    midStart;
  } vec_t;

  vec_t vecs [4];

  dpram_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(LAST), .SEED(SEED), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_err_addr(first_err_addr),
    .wen(wen), .waddr(waddr), .d_in(d_in), .ren(ren), .raddr(raddr), .d_out(d_out)
  );

  always #5 clk = ~clk;

  // Ideal registered-read dpram; faulty addresses return bit 5 flipped.
  always @(posedge clk) begin
    if (wen) mem[waddr] <= d_in;
    if (ren) d_out <= mem[raddr] ^ (faultMask[raddr] ? 32'h0000_0020 : 32'h0);
  end

  function automatic logic [31:0] nextLfsr(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int wTot, rTot, protoErr, doneAt, idx, ph;
    logic [31:0] expD;
    for (int i = 0; i <= LAST; i++) faultMask[i] = 1'b0;
    for (int i = 0; i < v.nf; i++) faultMask[v.fa[i]] = 1'b1;
    wTot = 0; rTot = 0; protoErr = 0; doneAt = -1;
    @(negedge clk) start = 1'b1;
    for (int n = 1; n <= 10000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        checkOutput({v.name, ".clearFail"}, 32'(fail_count), 32'd0);
        checkOutput({v.name, ".busyDone"}, {30'd0, busy, done}, 32'd2);
        checkOutput({v.name, ".firstWen"}, {31'd0, wen}, 32'd1);
        checkOutput({v.name, ".firstWaddr"}, 32'(waddr), 32'd0);
        checkOutput({v.name, ".firstDin"}, d_in, SEED);
      end
      if (v.midStart && n == 100) start = 1'b1;
      if (v.midStart && n == 101) start = 1'b0;
      if (wen && ren) protoErr++;
      if (wen) begin
        idx  = wTot % (LAST+1);
        ph   = wTot / (LAST+1);
        expD = (ph == 1) ? ~seq[idx] : seq[idx];
        if (32'(waddr) != idx || d_in != expD) protoErr++;
        wTot++;
      end
      if (ren) begin
        if (32'(raddr) != rTot % (LAST+1)) protoErr++;
        rTot++;
      end
      if (done) begin
        doneAt = n;
        break;
      end
      if (!busy) protoErr++;
    end
    checkOutput({v.name, ".doneCycle"}, doneAt, DONE_CYC);
    checkOutput({v.name, ".protocol"}, protoErr, 32'd0);
    checkOutput({v.name, ".writes"}, wTot, PASSES*(LAST+1));
    checkOutput({v.name, ".reads"}, rTot, PASSES*(LAST+1));
    checkOutput({v.name, ".failCount"}, 32'(fail_count), v.nf*PASSES);
    checkOutput({v.name, ".pass"}, {31'd0, pass}, (v.nf == 0) ? 32'd1 : 32'd0);
    checkOutput({v.name, ".busyAtDone"}, {31'd0, busy}, 32'd0);
    if (v.nf > 0) checkOutput({v.name, ".firstErr"}, 32'(first_err_addr), v.firstExp);
  endtask

  initial begin
    int bad;
    int found;
    vec_t clean;

    seq[0] = SEED;
    for (int i = 1; i <= LAST; i++) seq[i] = nextLfsr(seq[i-1]);

    vecs[0] = '{name: "clean",   nf: 0, fa: '{0, 0, 0},      firstExp: 0,     midStart: 1'b0};
    vecs[1] = '{name: "stuck",   nf: 1, fa: '{'h155, 0, 0},  firstExp: 'h155, midStart: 1'b0};
    vecs[2] = '{name: "multi",   nf: 3, fa: '{3, 700, 1023}, firstExp: 3,     midStart: 1'b0};
    vecs[3] = '{name: "restart", nf: 0, fa: '{0, 0, 0},      firstExp: 0,     midStart: 1'b1};
    clean   = vecs[0];

    for (int i = 0; i <= LAST; i++) faultMask[i] = 1'b0;

    // Reset and idle.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetBusyDone", {29'd0, busy, done, pass}, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done || pass || wen || ren || fail_count != 0 || first_err_addr != 0 ||
          waddr != 0 || raddr != 0 || d_in != 0) bad++;
    end
    checkOutput("idleOutputs", bad, 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Reset during READ at raddr 500, then a full clean run.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int n = 0; n < 5000; n++) begin
      if (ren && raddr == 10'd500) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("midRunReached", found, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRunReset", {28'd0, busy, done, wen, ren}, 32'd0);
    checkOutput("midRunFail", 32'(fail_count), 32'd0);
    @(negedge clk) rst = 1'b0;
    clean.name = "afterReset";
    applyStimulus(clean);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
